// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - operand-entry / mode-latch / calc-wait sequencer
// Moore FSM stepping operand writes, mode latch, ALU settle wait and done hold.
module calc_sequencer #(
  parameter int NUM_OPERANDS = 2,
  parameter int ADDR_W       = 2,
  parameter int MS_W         = 3,
  parameter int MS_OUT_W     = 4,
  parameter int CALC_CYCLES  = 1
) (
  input  logic                CLK,
  input  logic                clear,
  input  logic                next,
  input  logic                cancel,
  input  logic [MS_W-1:0]     MS,
  output logic                WE,
  output logic [ADDR_W-1:0]   W_addr,
  output logic [MS_OUT_W-1:0] MS_out,
  output logic [1:0]          LEDsel,
  output logic                Done_out
);

  localparam int CNT_W = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_OPERANDS - 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(CALC_CYCLES - 1);

  typedef enum logic [2:0] {
    S_WAIT_OP   = 3'd0,
    S_WRITE     = 3'd1,
    S_MODE_WAIT = 3'd2,
    S_CALC      = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [MS_OUT_W-1:0] ms_q, ms_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                next_prev_q, next_prev_d;
  logic                press;

  assign press = next & ~next_prev_q;

  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      state_q     <= S_WAIT_OP;
      idx_q       <= '0;
      ms_q        <= '0;
      cnt_q       <= '0;
      next_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ms_q        <= ms_d;
      cnt_q       <= cnt_d;
      next_prev_q <= next_prev_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ms_d        = ms_q;
    cnt_d       = cnt_q;
    next_prev_d = next;
    WE          = 1'b0;
    W_addr      = idx_q;
    MS_out      = '0;
    LEDsel      = 2'b00;
    Done_out    = 1'b0;

    case (state_q)
      S_WAIT_OP: begin
        if (press) state_d = S_WRITE;
      end
      S_WRITE: begin
        WE = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = S_MODE_WAIT;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_WAIT_OP;
        end
      end
      S_MODE_WAIT: begin
        LEDsel = 2'b01;
        if (press) begin
          ms_d    = MS_OUT_W'(MS);
          cnt_d   = CNT_INIT;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        LEDsel = 2'b01;
        MS_out = ms_q;
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_DONE: begin
        LEDsel   = 2'b10;
        MS_out   = ms_q;
        Done_out = 1'b1;
        if (press) begin
          idx_d   = '0;
          ms_d    = '0;
          state_d = S_WAIT_OP;
        end
      end
      default: begin
        // Unreachable encodings fall back to a clean start.
        state_d = S_WAIT_OP;
        idx_d   = '0;
        ms_d    = '0;
        cnt_d   = '0;
      end
    endcase

    // Abort wins over any press; the Moore WE of a WRITE cycle still shows.
    if (cancel) begin
      state_d = S_WAIT_OP;
      idx_d   = '0;
      ms_d    = '0;
      cnt_d   = '0;
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - directed bench for calc_sequencer
// Three operands, four calc cycles; linear directed steps with immediate assertions.
module tb_calc_sequencer;

  logic       CLK = 1'b0;
  logic       clear = 1'b0;
  logic       next = 1'b0;
  logic       cancel = 1'b0;
  logic [2:0] MS = 3'b000;
  logic       WE;
  logic [1:0] W_addr;
  logic [3:0] MS_out;
  logic [1:0] LEDsel;
  logic       Done_out;

  int total = 0;
  int bad = 0;

  calc_sequencer #(
    .NUM_OPERANDS(3),
    .ADDR_W(2),
    .MS_W(3),
    .MS_OUT_W(4),
    .CALC_CYCLES(4)
  ) dut (
    .CLK(CLK),
    .clear(clear),
    .next(next),
    .cancel(cancel),
    .MS(MS),
    .WE(WE),
    .W_addr(W_addr),
    .MS_out(MS_out),
    .LEDsel(LEDsel),
    .Done_out(Done_out)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic press();
    next = 1'b1;
    tick();
    next = 1'b0;
  endtask

  // Snapshot of all outputs: {WE, W_addr, MS_out, LEDsel, Done_out}
  function automatic logic [31:0] outs();
    return {22'd0, WE, W_addr, MS_out, LEDsel, Done_out};
  endfunction

  function automatic logic [31:0] mk(input logic we, input logic [1:0] a, input logic [3:0] m,
                                     input logic [1:0] l, input logic d);
    return {22'd0, we, a, m, l, d};
  endfunction

  task automatic write_op(input string tag, input logic [1:0] addr);
    press();
    chk({tag, "_we"}, outs(), mk(1'b1, addr, 4'h0, 2'b00, 1'b0));
    tick();
    chk({tag, "_we_drop"}, {31'd0, WE}, 32'd0);
  endtask

  initial begin
    // Reset
    #1 clear = 1'b1;
    #1;
    chk("reset_async", outs(), mk(1'b0, 2'd0, 4'h0, 2'b00, 1'b0));
    tick();
    tick();
    clear = 1'b0;
    chk("reset_held", outs(), mk(1'b0, 2'd0, 4'h0, 2'b00, 1'b0));

    // 1: three operands spaced 5 cycles apart
    for (int k = 0; k < 3; k++) begin
      repeat (4) tick();
      chk("t1_idle_we", {31'd0, WE}, 32'd0);
      write_op("t1_op", 2'(k));
    end
    chk("t1_mode_wait", outs(), mk(1'b0, 2'd2, 4'h0, 2'b01, 1'b0));

    // 2 + 5: mode latch, CALC length 4 with an ignored press inside
    MS = 3'b101;
    press();
    chk("t2_calc1", outs(), mk(1'b0, 2'd2, 4'h5, 2'b01, 1'b0));
    tick();
    chk("t2_calc2", outs(), mk(1'b0, 2'd2, 4'h5, 2'b01, 1'b0));
    press();
    chk("t5_calc3_press", outs(), mk(1'b0, 2'd2, 4'h5, 2'b01, 1'b0));
    tick();
    chk("t2_calc4", outs(), mk(1'b0, 2'd2, 4'h5, 2'b01, 1'b0));
    tick();
    chk("t2_done", outs(), mk(1'b0, 2'd2, 4'h5, 2'b10, 1'b1));
    MS = 3'b010;
    tick();
    chk("t2_ms_held", outs(), mk(1'b0, 2'd2, 4'h5, 2'b10, 1'b1));
    repeat (3) tick();
    chk("t2_done_hold", outs(), mk(1'b0, 2'd2, 4'h5, 2'b10, 1'b1));

    // 3: restart from DONE; then next held through WRITE gives one write only
    next = 1'b1;
    tick();
    chk("t3_restart", outs(), mk(1'b0, 2'd0, 4'h0, 2'b00, 1'b0));
    next = 1'b0;
    tick();
    next = 1'b1;
    tick();
    chk("t3_write0", outs(), mk(1'b1, 2'd0, 4'h0, 2'b00, 1'b0));
    tick();
    chk("t5_after_write", outs(), mk(1'b0, 2'd1, 4'h0, 2'b00, 1'b0));
    tick();
    chk("t5_held_no_write", outs(), mk(1'b0, 2'd1, 4'h0, 2'b00, 1'b0));

    // 4: next held through clear release is not a press
    clear = 1'b1;
    #1;
    chk("t4_clear_async", outs(), mk(1'b0, 2'd0, 4'h0, 2'b00, 1'b0));
    tick();
    clear = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t4_held_we", {31'd0, WE}, 32'd0);
    end
    next = 1'b0;
    tick();
    write_op("t4_op", 2'd0);
    chk("t4_addr_after", {30'd0, W_addr}, 32'd1);

    // 6a: cancel in MODE_WAIT with idx=2
    write_op("t6_op1", 2'd1);
    write_op("t6_op2", 2'd2);
    chk("t6_mode_wait", outs(), mk(1'b0, 2'd2, 4'h0, 2'b01, 1'b0));
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("t6_cancel", outs(), mk(1'b0, 2'd0, 4'h0, 2'b00, 1'b0));

    // cancel coinciding with WRITE: strobe shows, idx returns to 0
    tick();
    press();
    cancel = 1'b1;
    chk("t6_cw_we", outs(), mk(1'b1, 2'd0, 4'h0, 2'b00, 1'b0));
    tick();
    cancel = 1'b0;
    chk("t6_cw_after", outs(), mk(1'b0, 2'd0, 4'h0, 2'b00, 1'b0));

    // 6b: async clear mid-CALC
    tick();
    write_op("t6b_op0", 2'd0);
    write_op("t6b_op1", 2'd1);
    write_op("t6b_op2", 2'd2);
    MS = 3'b111;
    press();
    chk("t6b_calc", outs(), mk(1'b0, 2'd2, 4'h7, 2'b01, 1'b0));
    tick();
    #2 clear = 1'b1;
    #1;
    chk("t6b_clear_async", outs(), mk(1'b0, 2'd0, 4'h0, 2'b00, 1'b0));
    tick();
    clear = 1'b0;
    tick();
    chk("t6b_after_clear", outs(), mk(1'b0, 2'd0, 4'h0, 2'b00, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
